// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : RV32 subset instruction decode. Reads the 32x32 register file
//            (with same-cycle writeback bypass), resolves beq/bne/jal in ID,
//            detects load-use and branch-operand hazards, squashes the
//            instruction fetched behind a redirect, and drives the ID/EX
//            pipeline register.
// Config   : DECODE_FWD_M_EN - when defined, a non-load ALU result in MEM
//            (ALUOutM) is forwarded into the branch comparator instead of
//            stalling.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCPD,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic [31:0] ALUOutM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    output logic        PCSrcD,
    output logic [31:0] PCBranchD,
    output logic        StallF,
    output logic        StallD,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmE,
    output logic [14:0] RegsE,
    output logic [7:0]  CtrlE
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;

    localparam int NUM_REGS = 32;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] rf_q [NUM_REGS];
    logic        squash_q,  squash_d;
    logic [7:0]  ctrl_e_q,  ctrl_e_d;
    logic [14:0] regs_e_q,  regs_e_d;
    logic [31:0] rd1_e_q,   rd1_e_d;
    logic [31:0] rd2_e_q,   rd2_e_d;
    logic [31:0] imm_e_q,   imm_e_d;

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;

    assign w_opcode = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign w_funct7 = InstrD[31:25];
    assign w_rs1    = InstrD[19:15];
    assign w_rs2    = InstrD[24:20];
    assign w_rd     = InstrD[11:7];

    assign w_imm_i  = {{20{InstrD[31]}}, InstrD[31:20]};
    assign w_imm_s  = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign w_imm_b  = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                       InstrD[30:25], InstrD[11:8], 1'b0};
    assign w_imm_j  = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                       InstrD[20], InstrD[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    logic        w_valid;
    logic        w_use1;
    logic        w_use2;
    logic        w_use_rd;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_reg_write;
    logic        w_mem_to_reg;
    logic        w_mem_write;
    logic        w_alu_src;
    logic [3:0]  w_alu_ctrl;
    logic [31:0] w_imm_e;

    // Classify InstrD; anything outside the supported subset stays invalid.
    always_comb begin
        w_valid      = 1'b0;
        w_use1       = 1'b0;
        w_use2       = 1'b0;
        w_use_rd     = 1'b0;
        w_is_branch  = 1'b0;
        w_is_jal     = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_ctrl   = ALU_ADD;
        w_imm_e      = '0;
        case (w_opcode)
            OP_R: begin
                w_valid = 1'b1;
                case ({w_funct7, w_funct3})
                    {F7_BASE, F3_ADD}: w_alu_ctrl = ALU_ADD;
                    {F7_ALT,  F3_ADD}: w_alu_ctrl = ALU_SUB;
                    {F7_BASE, F3_AND}: w_alu_ctrl = ALU_AND;
                    {F7_BASE, F3_OR }: w_alu_ctrl = ALU_OR;
                    {F7_BASE, F3_XOR}: w_alu_ctrl = ALU_XOR;
                    {F7_BASE, F3_SLT}: w_alu_ctrl = ALU_SLT;
                    default:           w_valid    = 1'b0;
                endcase
                w_use1      = w_valid;
                w_use2      = w_valid;
                w_use_rd    = w_valid;
                w_reg_write = w_valid;
            end
            OP_I: begin
                w_valid = 1'b1;
                case (w_funct3)
                    F3_ADD:  w_alu_ctrl = ALU_ADD;
                    F3_AND:  w_alu_ctrl = ALU_AND;
                    F3_OR:   w_alu_ctrl = ALU_OR;
                    F3_XOR:  w_alu_ctrl = ALU_XOR;
                    F3_SLT:  w_alu_ctrl = ALU_SLT;
                    default: w_valid    = 1'b0;
                endcase
                w_use1      = w_valid;
                w_use_rd    = w_valid;
                w_reg_write = w_valid;
                w_alu_src   = w_valid;
                w_imm_e     = w_imm_i;
            end
            OP_LOAD: begin
                if (w_funct3 == F3_WORD) begin
                    w_valid      = 1'b1;
                    w_use1       = 1'b1;
                    w_use_rd     = 1'b1;
                    w_reg_write  = 1'b1;
                    w_mem_to_reg = 1'b1;
                    w_alu_src    = 1'b1;
                    w_imm_e      = w_imm_i;
                end
            end
            OP_STORE: begin
                if (w_funct3 == F3_WORD) begin
                    w_valid     = 1'b1;
                    w_use1      = 1'b1;
                    w_use2      = 1'b1;
                    w_mem_write = 1'b1;
                    w_alu_src   = 1'b1;
                    w_imm_e     = w_imm_s;
                end
            end
            OP_BRANCH: begin
                // Branches complete in ID; they never carry work into EX.
                if ((w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE)) begin
                    w_valid     = 1'b1;
                    w_is_branch = 1'b1;
                    w_use1      = 1'b1;
                    w_use2      = 1'b1;
                end
            end
            OP_JAL: begin
                // rd <- PC+4 is computed in EX as PCPD + 0.
                w_valid     = 1'b1;
                w_is_jal    = 1'b1;
                w_use_rd    = 1'b1;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Register read with writeback bypass
    // ------------------------------------------------------------------
    logic [31:0] w_rf1;
    logic [31:0] w_rf2;

    // A write landing this cycle is visible to the read in the same cycle.
    always_comb begin
        w_rf1 = rf_q[w_rs1];
        w_rf2 = rf_q[w_rs2];
        if (w_rs1 == 5'd0) begin
            w_rf1 = '0;
        end else if (RegWriteW && (WriteRegW == w_rs1)) begin
            w_rf1 = ResultW;
        end
        if (w_rs2 == 5'd0) begin
            w_rf2 = '0;
        end else if (RegWriteW && (WriteRegW == w_rs2)) begin
            w_rf2 = ResultW;
        end
    end

    // ------------------------------------------------------------------
    // Branch comparator operands and MEM-stage hazard class
    // ------------------------------------------------------------------
    logic [31:0] w_br1;
    logic [31:0] w_br2;
    logic        w_m_blocks;

`ifdef DECODE_FWD_M_EN
    logic        w_m_fwd_ok;
    assign w_m_fwd_ok = RegWriteM && !MemtoRegM && (RdM != 5'd0);

    // Non-load MEM results are forwarded; only a load in MEM must wait.
    always_comb begin
        w_br1 = w_rf1;
        w_br2 = w_rf2;
        if (w_m_fwd_ok && (RdM == w_rs1)) begin
            w_br1 = ALUOutM;
        end
        if (w_m_fwd_ok && (RdM == w_rs2)) begin
            w_br2 = ALUOutM;
        end
    end
    assign w_m_blocks = MemtoRegM;
`else
    logic        w_unused_alu_m;
    assign w_unused_alu_m = ^ALUOutM;
    assign w_br1          = w_rf1;
    assign w_br2          = w_rf2;
    // Any register producer in MEM blocks the branch until it reaches W.
    assign w_m_blocks     = MemtoRegM || RegWriteM;
`endif

    // ------------------------------------------------------------------
    // Hazards, branch resolution and squash
    // ------------------------------------------------------------------
    logic [4:0]  w_rd_e;
    logic        w_load_use;
    logic        w_br_hz_e;
    logic        w_br_hz_m;
    logic        w_stall;
    logic        w_take;
    logic        w_issue;

    assign w_rd_e     = regs_e_q[4:0];

    assign w_load_use = ctrl_e_q[6] && (w_rd_e != 5'd0) &&
                        ((w_use1 && (w_rs1 == w_rd_e)) ||
                         (w_use2 && (w_rs2 == w_rd_e)));

    assign w_br_hz_e  = w_is_branch && ctrl_e_q[7] && (w_rd_e != 5'd0) &&
                        ((w_rs1 == w_rd_e) || (w_rs2 == w_rd_e));

    assign w_br_hz_m  = w_is_branch && w_m_blocks && (RdM != 5'd0) &&
                        ((w_rs1 == RdM) || (w_rs2 == RdM));

    // Squash wins over stall; reset silences both.
    assign w_stall    = rst_n && !squash_q &&
                        (w_load_use || w_br_hz_e || w_br_hz_m);

    assign w_take     = w_is_jal ||
                        (w_is_branch && (w_funct3[0] ? (w_br1 != w_br2)
                                                     : (w_br1 == w_br2)));

    assign PCSrcD     = rst_n && !squash_q && !w_stall && w_take;
    assign PCBranchD  = (PCPD - 32'd4) + (w_is_jal ? w_imm_j : w_imm_b);
    assign StallF     = w_stall;
    assign StallD     = w_stall;

    // The slot behind a taken redirect is dead for exactly one cycle.
    assign squash_d   = PCSrcD;

    // ------------------------------------------------------------------
    // ID/EX next state
    // ------------------------------------------------------------------
    assign w_issue    = w_valid && !w_is_branch && !squash_q && !w_stall;

    // Load the decoded instruction, or an all-zero bubble.
    always_comb begin
        ctrl_e_d = '0;
        regs_e_d = '0;
        rd1_e_d  = '0;
        rd2_e_d  = '0;
        imm_e_d  = '0;
        if (w_issue) begin
            ctrl_e_d = {w_reg_write, w_mem_to_reg, w_mem_write, w_alu_src, w_alu_ctrl};
            regs_e_d = {(w_use1   ? w_rs1 : 5'd0),
                        (w_use2   ? w_rs2 : 5'd0),
                        (w_use_rd ? w_rd  : 5'd0)};
            rd1_e_d  = w_is_jal ? PCPD : (w_use1 ? w_rf1 : 32'd0);
            rd2_e_d  = w_use2 ? w_rf2 : 32'd0;
            imm_e_d  = w_imm_e;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // Register file: x0 is never written; reset clears every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RegWriteW && (WriteRegW != 5'd0)) begin
            rf_q[WriteRegW] <= ResultW;
        end
    end

    // ID/EX register and squash flop advance every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_e_q <= '0;
            regs_e_q <= '0;
            rd1_e_q  <= '0;
            rd2_e_q  <= '0;
            imm_e_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            ctrl_e_q <= ctrl_e_d;
            regs_e_q <= regs_e_d;
            rd1_e_q  <= rd1_e_d;
            rd2_e_q  <= rd2_e_d;
            imm_e_q  <= imm_e_d;
            squash_q <= squash_d;
        end
    end

    assign CtrlE = ctrl_e_q;
    assign RegsE = regs_e_q;
    assign RD1E  = rd1_e_q;
    assign RD2E  = rd2_e_q;
    assign ImmE  = imm_e_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage. A behavioural model of the
//            decode rules predicts every output each cycle; directed
//            scenarios are followed by randomized instruction streams.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    localparam int K_BUB = 0;
    localparam int K_R   = 1;
    localparam int K_I   = 2;
    localparam int K_LW  = 3;
    localparam int K_SW  = 4;
    localparam int K_BR  = 5;
    localparam int K_JAL = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] InstrD;
    logic [31:0] PCPD;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [31:0] ALUOutM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic        MemtoRegM;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        StallF;
    logic        StallD;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] ImmE;
    logic [14:0] RegsE;
    logic [7:0]  CtrlE;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .InstrD    (InstrD),
        .PCPD      (PCPD),
        .RegWriteW (RegWriteW),
        .WriteRegW (WriteRegW),
        .ResultW   (ResultW),
        .ALUOutM   (ALUOutM),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .StallF    (StallF),
        .StallD    (StallD),
        .RD1E      (RD1E),
        .RD2E      (RD2E),
        .ImmE      (ImmE),
        .RegsE     (RegsE),
        .CtrlE     (CtrlE)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state: architectural registers and ID/EX contents.
    logic [31:0] m_rf [32];
    logic [7:0]  m_ctrl;
    logic [14:0] m_regs;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic        m_squash;
    logic [7:0]  n_ctrl;
    logic [14:0] n_regs;
    logic [31:0] n_rd1, n_rd2, n_imm;
    logic        n_squash;
    logic        e_stall, e_pcsrc;
    logic [31:0] e_pcbr;
    logic        s_stall_f, s_stall_d, s_pcsrc;
    logic [31:0] s_pcbr;

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic signed [31:0] t;
        t = $signed(v << (32 - n));
        return t >>> (32 - n);
    endfunction

    // funct3 -> ALU op shared by R and I arithmetic; -1 for unsupported.
    function automatic int alu_of_f3(input logic [2:0] f3);
        case (f3)
            3'd0:    return 0;
            3'd7:    return 2;
            3'd6:    return 3;
            3'd4:    return 4;
            3'd2:    return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (RegWriteW && (WriteRegW == r)) return ResultW;
        return m_rf[r];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_ctrl = '0; m_regs = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_squash = 1'b0;
    endtask

    task automatic model_eval();
        int          kind, a;
        logic [3:0]  alu;
        logic        u1, u2, hrd, asrc, lu, bs, taken, issue;
        logic [4:0]  rs1, rs2, rd, rde;
        logic [31:0] v1, v2, o1, o2, imm, timm;
        rs1  = InstrD[19:15];
        rs2  = InstrD[24:20];
        rd   = InstrD[11:7];
        kind = K_BUB;
        alu  = 4'd0;
        a    = alu_of_f3(InstrD[14:12]);
        case (InstrD[6:0])
            7'h33: begin
                if (InstrD[31:25] == 7'h00 && a >= 0) begin kind = K_R; alu = 4'(a); end
                else if (InstrD[31:25] == 7'h20 && InstrD[14:12] == 3'd0) begin kind = K_R; alu = 4'd1; end
            end
            7'h13: if (a >= 0) begin kind = K_I; alu = 4'(a); end
            7'h03: if (InstrD[14:12] == 3'd2) kind = K_LW;
            7'h23: if (InstrD[14:12] == 3'd2) kind = K_SW;
            7'h63: if (InstrD[14:12] <= 3'd1) kind = K_BR;
            7'h6f: kind = K_JAL;
            default: ;
        endcase
        u1   = kind inside {K_R, K_I, K_LW, K_SW, K_BR};
        u2   = kind inside {K_R, K_SW, K_BR};
        hrd  = kind inside {K_R, K_I, K_LW, K_JAL};
        asrc = kind inside {K_I, K_LW, K_SW, K_JAL};
        case (kind)
            K_I, K_LW: imm = sext(InstrD >> 20, 12);
            K_SW:      imm = sext((32'(InstrD[31:25]) << 5) | 32'(InstrD[11:7]), 12);
            default:   imm = 32'd0;
        endcase
        if (kind == K_JAL)
            timm = sext((32'(InstrD[31]) << 20) | (32'(InstrD[19:12]) << 12) |
                        (32'(InstrD[20]) << 11) | (32'(InstrD[30:21]) << 1), 21);
        else
            timm = sext((32'(InstrD[31]) << 12) | (32'(InstrD[7]) << 11) |
                        (32'(InstrD[30:25]) << 5) | (32'(InstrD[11:8]) << 1), 13);
        v1 = rdval(rs1);
        v2 = rdval(rs2);
        o1 = v1;
        o2 = v2;
`ifdef DECODE_FWD_M_EN
        if (RegWriteM && !MemtoRegM && RdM != 5'd0) begin
            if (RdM == rs1) o1 = ALUOutM;
            if (RdM == rs2) o2 = ALUOutM;
        end
`endif
        rde = m_regs[4:0];
        lu  = m_ctrl[6] && rde != 5'd0 && ((u1 && rs1 == rde) || (u2 && rs2 == rde));
        bs  = 1'b0;
        if (kind == K_BR) begin
            if (m_ctrl[7] && rde != 5'd0 && (rs1 == rde || rs2 == rde)) bs = 1'b1;
            if (MemtoRegM && RdM != 5'd0 && (rs1 == RdM || rs2 == RdM)) bs = 1'b1;
`ifndef DECODE_FWD_M_EN
            if (RegWriteM && RdM != 5'd0 && (rs1 == RdM || rs2 == RdM)) bs = 1'b1;
`endif
        end
        e_stall  = rst_n && !m_squash && (lu || bs);
        taken    = (kind == K_JAL) ||
                   (kind == K_BR && (InstrD[12] ? (o1 != o2) : (o1 == o2)));
        e_pcsrc  = rst_n && !m_squash && !e_stall && taken;
        e_pcbr   = PCPD - 32'd4 + timm;
        issue    = rst_n && !m_squash && !e_stall && (kind inside {K_R, K_I, K_LW, K_SW, K_JAL});
        n_ctrl   = issue ? {hrd, kind == K_LW, kind == K_SW, asrc, alu} : 8'd0;
        n_regs   = issue ? {(u1 ? rs1 : 5'd0), (u2 ? rs2 : 5'd0), (hrd ? rd : 5'd0)} : 15'd0;
        n_rd1    = !issue ? 32'd0 : (kind == K_JAL) ? PCPD : (u1 ? v1 : 32'd0);
        n_rd2    = (issue && u2) ? v2 : 32'd0;
        n_imm    = issue ? imm : 32'd0;
        n_squash = e_pcsrc;
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_clear();
        end else begin
            if (RegWriteW && WriteRegW != 5'd0) m_rf[WriteRegW] = ResultW;
            m_ctrl = n_ctrl; m_regs = n_regs; m_rd1 = n_rd1; m_rd2 = n_rd2;
            m_imm = n_imm; m_squash = n_squash;
        end
    endtask

    // One clock: inputs already applied just after the previous edge.
    task automatic step();
        model_eval();
        #3;
        s_stall_f = StallF;
        s_stall_d = StallD;
        s_pcsrc   = PCSrcD;
        s_pcbr    = PCBranchD;
        check("StallF", 32'(StallF), 32'(e_stall));
        check("StallD", 32'(StallD), 32'(e_stall));
        check("PCSrcD", 32'(PCSrcD), 32'(e_pcsrc));
        if (e_pcsrc) check("PCBranchD", PCBranchD, e_pcbr);
        check("CtrlE", 32'(CtrlE), 32'(m_ctrl));
        check("RegsE", 32'(RegsE), 32'(m_regs));
        check("RD1E", RD1E, m_rd1);
        check("RD2E", RD2E, m_rd2);
        check("ImmE", ImmE, m_imm);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, d;
        logic [2:0] f3;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1: begin
                case ($urandom_range(0, 6))
                    0: f3 = 3'd0;
                    1: f3 = 3'd7;
                    2: f3 = 3'd6;
                    3: f3 = 3'd4;
                    4: f3 = 3'd2;
                    5: return enc_r(7'h20, b, a, 3'd0, d);
                    default: return enc_r(7'h01, b, a, 3'd0, d);
                endcase
                return enc_r(7'h00, b, a, f3, d);
            end
            2: return enc_i(12'($urandom), a, 3'($urandom_range(0, 7)), d, 7'h13);
            3: return enc_i(12'($urandom), a, ($urandom_range(0, 4) == 0) ? 3'd0 : 3'd2, d, 7'h03);
            4: return enc_s(12'($urandom), b, a);
            5, 6: return enc_b(13'($urandom) & 13'h1ffe, b, a, 3'($urandom_range(0, 2)));
            7: return enc_j(21'($urandom) & 21'h1ffffe, d);
            8: return $urandom();
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; InstrD = '0; PCPD = '0; RegWriteW = 1'b0; WriteRegW = '0;
        ResultW = '0; ALUOutM = '0; RdM = '0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        InstrD = enc_j(21'd64, 5'd1);
        step();                                     // reset held: outputs quiet
        rst_n = 1'b1;
        InstrD = 32'd0;
        step();

        // Same-cycle writeback bypass into an add.
        RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'd7;
        InstrD = enc_r(7'h00, 5'd5, 5'd5, 3'd0, 5'd6);
        step();
        RegWriteW = 1'b0; InstrD = 32'd0;
        check("bypass_rd1", RD1E, 32'd7);
        check("bypass_rd2", RD2E, 32'd7);
        check("bypass_ctrl", 32'(CtrlE), 32'h80);

        // Load-use: one stall cycle with a bubble, then the add issues.
        InstrD = enc_i(12'd0, 5'd0, 3'd2, 5'd3, 7'h03);
        step();
        InstrD = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4);
        step();
        check("lu_stallF", 32'(s_stall_f), 32'd1);
        check("lu_stallD", 32'(s_stall_d), 32'd1);
        check("lu_bubble", 32'(CtrlE), 32'd0);
        step();
        check("lu_release", 32'(s_stall_d), 32'd0);
        check("lu_issue_ctrl", 32'(CtrlE), 32'h80);
        check("lu_issue_regs", 32'(RegsE), 32'({5'd3, 5'd0, 5'd4}));
        InstrD = 32'd0;
        step();

        // Taken beq then squash of the following slot.
        RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'd9;
        step();
        WriteRegW = 5'd2;
        step();
        RegWriteW = 1'b0;
        PCPD = 32'h104; InstrD = enc_b(13'd16, 5'd2, 5'd1, 3'd0);
        step();
        check("beq_taken", 32'(s_pcsrc), 32'd1);
        check("beq_target", s_pcbr, 32'h110);
        check("beq_no_ex", 32'(CtrlE), 32'd0);
        PCPD = 32'h108; InstrD = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7);
        step();
        check("squash_pcsrc", 32'(s_pcsrc), 32'd0);
        check("squash_stall", 32'(s_stall_d), 32'd0);
        check("squash_ctrl", 32'(CtrlE), 32'd0);
        InstrD = 32'd0;
        step();

        // Branch operand produced by an ALU op in MEM.
        RdM = 5'd1; RegWriteM = 1'b1; MemtoRegM = 1'b0; ALUOutM = 32'd3;
        PCPD = 32'h204; InstrD = enc_b(13'd16, 5'd0, 5'd1, 3'd0);
        step();
`ifdef DECODE_FWD_M_EN
        check("fwdm_stall", 32'(s_stall_d), 32'd0);
        check("fwdm_pcsrc", 32'(s_pcsrc), 32'd0);
`else
        check("fwdm_stall", 32'(s_stall_d), 32'd1);
        check("fwdm_pcsrc", 32'(s_pcsrc), 32'd0);
`endif
        RdM = 5'd0; RegWriteM = 1'b0;
        RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'd3;
        step();
        check("fwdm_w_stall", 32'(s_stall_d), 32'd0);
        check("fwdm_w_pcsrc", 32'(s_pcsrc), 32'd0);

        // Reset in the middle of a load-use stall.
        WriteRegW = 5'd5; ResultW = 32'd11;
        InstrD = enc_i(12'd0, 5'd0, 3'd2, 5'd3, 7'h03);
        step();
        RegWriteW = 1'b0;
        InstrD = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4);
        rst_n = 1'b0;
        step();
        check("rst_stall_during", 32'(s_stall_d), 32'd0);
        check("rst_ctrl", 32'(CtrlE), 32'd0);
        rst_n = 1'b1;
        InstrD = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd6);
        step();
        check("rst_stall_after", 32'(s_stall_d), 32'd0);
        check("rst_x5_cleared", RD1E, 32'd0);
        check("rst_add_ctrl", 32'(CtrlE), 32'h80);

        // Randomized streams; IF/ID holds its instruction while stalled.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            RegWriteW = 1'($urandom_range(0, 1));
            WriteRegW = 5'($urandom_range(0, 7));
            ResultW   = 32'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1));
            MemtoRegM = ($urandom_range(0, 3) == 0);
            RdM       = 5'($urandom_range(0, 7));
            ALUOutM   = 32'($urandom_range(0, 3));
            if (!e_stall) begin
                InstrD = rand_instr();
                PCPD   = $urandom() & 32'hffff_fffc;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 One clock; reset is synchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 InstrD  in  32  instruction from the IF/ID register.
REQ-005 PCPD  in  32  PC+4 of InstrD.
REQ-006 RegWriteW  in  1  writeback enable.
REQ-007 WriteRegW  in  5  writeback destination.
REQ-008 ResultW  in  32  writeback data.
REQ-009 ALUOutM  in  32  ALU result in MEM.
REQ-010 RdM  in  5  destination in MEM.
REQ-011 RegWriteM  in  1  MEM writes a register.
REQ-012 MemtoRegM  in  1  MEM instruction is a load.
REQ-013 PCSrcD  out  1  redirect fetch, taken beq/bne or jal.
REQ-014 PCBranchD  out  32  redirect target, (PCPD-4)+imm.
REQ-015 StallF  out  1  hold PC.
REQ-016 StallD  out  1  hold IF/ID.
REQ-017 RD1E, RD2E  out  32 each  ID/EX operands.
REQ-018 ImmE  out  32  ID/EX sign-extended immediate.
REQ-019 RegsE  out  15  ID/EX {rs1,rs2,rd}.
REQ-020 CtrlE  out  8  ID/EX {RegWrite,MemtoReg,MemWrite,ALUSrc,ALUControl[3:0]}.

Function
REQ-021 Decode: R add/sub/and/or/xor/slt; I addi/andi/ori/xori/slti; lw; sw; beq; bne; jal. Any other opcode is a bubble.
REQ-022 ALUControl encodings: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101.
REQ-023 Immediates: I, S, B and J formats are each sign-extended to 32 bits. B and J immediates have bit0=0.
REQ-024 Register file: 32x32. x0 reads 0 and ignores writes. Writes occur at posedge when RegWriteW=1.
REQ-025 Register read bypass: a same-cycle write to a register being read returns ResultW.
REQ-026 jal: RD1E=PCPD, ImmE=0, ALUSrc=1, ALU op ADD, so that rd receives PC+4.
REQ-027 Branch compare uses the read/bypassed register values. beq is taken on equal, bne on not-equal. jal is always taken.
REQ-028 ID/EX register updates every cycle, 1-cycle latency. A bubble loads CtrlE=0, RegsE=0, RD1E=RD2E=ImmE=0.
REQ-029 Load-use stall condition: CtrlE.MemtoReg=1, RdE!=0, and RdE equals a source that InstrD uses.
REQ-030 Branch stall condition (beq/bne only):
  - RegWriteE=1, RdE!=0, RdE equals rs1 or rs2; or
  - MemtoRegM=1, RdM!=0, RdM equals rs1 or rs2.
REQ-031 On any stall: StallF=StallD=1, PCSrcD=0, and a bubble is inserted into ID/EX.
REQ-032 Squash: a 1-bit flop is set when PCSrcD=1 and is cleared the following cycle. While it is set:
  - InstrD is treated as a bubble;
  - PCSrcD=0;
  - no stall is raised.
REQ-033 Stall and squash are never asserted together. Squash has priority.
REQ-034 PCBranchD wraps modulo 2^32.

Reset
REQ-035 While rst_n=0 at posedge, all 32 registers, the ID/EX register and the squash flop clear to 0.
REQ-036 Outputs during and immediately after reset: CtrlE=0, RegsE=0, RD1E=RD2E=ImmE=0, PCSrcD=0, StallF=StallD=0.
REQ-037 Reset asserted mid-stall or mid-squash discards that state. No write from W is committed in a reset cycle.

Configuration
REQ-038 Macro DECODE_FWD_M_EN:
  - Defined: branch operands matching RdM with RegWriteM=1 and MemtoRegM=0 take ALUOutM, with no stall.
  - Undefined: that case raises a branch stall (REQ-031) until the producer reaches W.

Verification
REQ-039 Write x5=7 via W, then decode "add x6,x5,x5" the same cycle -> RD1E=RD2E=7 next cycle, CtrlE=8'b1000_0000.
REQ-040 Decode lw x3 then "add x4,x3,x0" -> one cycle with StallF=StallD=1, CtrlE=0, then the add issues.
REQ-041 x1=x2=9, decode beq x1,x2,+16 at PC 0x100 -> PCSrcD=1, PCBranchD=0x110; next cycle CtrlE=0 (squash).
REQ-042 ALUOutM=3 into x1 (RdM=1, RegWriteM=1), beq x1,x0 -> with macro: not taken, no stall; without macro: StallD=1 for one cycle.
REQ-043 rst_n=0 during a load-use stall -> next cycle StallD=0, CtrlE=0, and x5 reads 0.
